// File: rtl/amo_sequencer.sv
// amo_sequencer: runs RV64A AMO/LR/SC as memory read -> shared-ALU execute -> memory write, and owns the LR/SC reservation.
// Optional reservation expiry is enabled by defining AMO_RESV_TIMEOUT_EN.
module amo_sequencer #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 64,
  parameter int RESV_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_kind,
  input  logic [4:0]            req_amo_op,
  input  logic                  req_word,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic                  mem_req_word,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
  output logic [DATA_WIDTH-1:0] alu_operand_a,
  output logic [DATA_WIDTH-1:0] alu_operand_b,
  output logic [3:0]            alu_control,
  output logic [4:0]            alu_amo_op,
  output logic                  alu_word_operation,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  snoop_valid,
  input  logic [ADDR_WIDTH-1:0] snoop_addr
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, EXEC, WR_REQ, RESP} state_t;

  localparam logic [1:0] KIND_LR = 2'b01;
  localparam logic [1:0] KIND_SC = 2'b10;
  localparam int         DW_W    = ADDR_WIDTH - 3;

  state_t                       state_q, state_d;
  logic                         lr_p0, sc_p0, word_p0;
  logic [4:0]                   amo_op_p0;
  logic [ADDR_WIDTH-1:0]        addr_p0;
  logic signed [DATA_WIDTH-1:0] wdata_p0, old_p1, res_p2, rsp_data_q;
  logic                         resv_valid;
  logic [DW_W-1:0]              resv_addr;
  logic                         resv_expire;

  function automatic logic signed [DATA_WIDTH-1:0] load_extend(input logic word,
                                                               input logic [DATA_WIDTH-1:0] raw);
    if (word) return {{(DATA_WIDTH-32){raw[31]}}, raw[31:0]};
    return raw;
  endfunction

  logic                         accept, req_lr, req_sc, snoop_on_resv, sc_hit;
  logic                         rd_done, wr_done, lr_snooped;
  logic signed [DATA_WIDTH-1:0] rd_value;
  logic                         unused_bits;

  assign accept        = (state_q == IDLE) && req_valid;
  assign req_lr        = (req_kind == KIND_LR);
  assign req_sc        = (req_kind == KIND_SC);
  // A snoop landing in the SC acceptance cycle must already count as a miss.
  assign snoop_on_resv = snoop_valid && resv_valid && (snoop_addr[ADDR_WIDTH-1:3] == resv_addr);
  assign sc_hit        = resv_valid && (req_addr[ADDR_WIDTH-1:3] == resv_addr) && !snoop_on_resv;
  assign rd_done       = (state_q == RD_WAIT) && mem_rsp_valid;
  assign wr_done       = (state_q == WR_REQ) && mem_req_ready;
  assign lr_snooped    = snoop_valid && (snoop_addr[ADDR_WIDTH-1:3] == addr_p0[ADDR_WIDTH-1:3]);
  assign rd_value      = load_extend(word_p0, mem_rsp_rdata);
  assign unused_bits   = ^{req_addr[2:0], snoop_addr[2:0], (RESV_TIMEOUT > 0)};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_sc ? (sc_hit ? WR_REQ : RESP) : RD_REQ;
      RD_REQ:  if (mem_req_ready) state_d = RD_WAIT;
      RD_WAIT: if (mem_rsp_valid) state_d = lr_p0 ? RESP : EXEC;
      EXEC:    state_d = WR_REQ;
      WR_REQ:  if (mem_req_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // p0: request capture, p1: old memory value, p2: ALU result
  always_ff @(posedge clk) begin
    if (accept) begin
      lr_p0     <= req_lr;
      sc_p0     <= req_sc;
      word_p0   <= req_word;
      amo_op_p0 <= req_amo_op;
      addr_p0   <= req_addr;
      wdata_p0  <= req_wdata;
    end
    if (rd_done) old_p1 <= rd_value;
    if (state_q == EXEC) res_p2 <= alu_result;
  end

  always_ff @(posedge clk) begin
    if (rst)                         rsp_data_q <= '0;
    else if (accept && req_sc && !sc_hit) rsp_data_q <= DATA_WIDTH'(1);
    else if (rd_done && lr_p0)       rsp_data_q <= rd_value;
    else if (wr_done)                rsp_data_q <= sc_p0 ? '0 : old_p1;
  end

  // Later statements take priority: LR completion overrides the generic clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      resv_valid <= 1'b0;
    end else begin
      if (snoop_on_resv || resv_expire) resv_valid <= 1'b0;
      if (wr_done && !sc_p0 && (addr_p0[ADDR_WIDTH-1:3] == resv_addr)) resv_valid <= 1'b0;
      if (accept && req_sc) resv_valid <= 1'b0;
      if (rd_done && lr_p0) resv_valid <= !lr_snooped;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_done && lr_p0) resv_addr <= addr_p0[ADDR_WIDTH-1:3];
  end

`ifdef AMO_RESV_TIMEOUT_EN
  localparam int CNT_W = $clog2(RESV_TIMEOUT + 1);
  logic [CNT_W-1:0] resv_cnt;

  always_ff @(posedge clk) begin
    if (rst)                             resv_cnt <= '0;
    else if (rd_done && lr_p0)           resv_cnt <= CNT_W'(RESV_TIMEOUT);
    else if (resv_valid && resv_cnt != 0) resv_cnt <= resv_cnt - 1'b1;
  end

  assign resv_expire = resv_valid && (resv_cnt == '0);
`else
  assign resv_expire = 1'b0;
`endif

  assign req_ready          = (state_q == IDLE);
  assign mem_req_valid      = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem_req_we         = (state_q == WR_REQ);
  assign mem_req_word       = word_p0;
  assign mem_req_addr       = addr_p0;
  assign mem_req_wdata      = sc_p0 ? wdata_p0 : res_p2;
  assign alu_operand_a      = old_p1;
  assign alu_operand_b      = wdata_p0;
  assign alu_control        = (state_q == EXEC) ? 4'b1110 : 4'b0000;
  assign alu_amo_op         = amo_op_p0;
  assign alu_word_operation = word_p0;
  assign rsp_valid          = (state_q == RESP);
  assign rsp_data           = rsp_data_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer: zero-wait memory model, stub ALU, LR/SC reservation scenarios.
module tb_amo_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_kind = 2'b00;
  logic [4:0]  req_amo_op = 5'b0;
  logic        req_word = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        mem_req_valid, mem_req_we, mem_req_word;
  logic        mem_req_ready = 1'b1;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_rdata = '0;
  logic [63:0] alu_operand_a, alu_operand_b, alu_result;
  logic [3:0]  alu_control;
  logic [4:0]  alu_amo_op;
  logic        alu_word_operation;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        snoop_valid = 1'b0;
  logic [63:0] snoop_addr = '0;

  int errors = 0;
  int checks = 0;

  logic [63:0] mem [logic [63:0]];
  logic        mem_mute = 1'b0;
  int          wr_count = 0;
  logic [63:0] last_wr_addr = '0, last_wr_data = '0;

  amo_sequencer #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .RESV_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind), .req_amo_op(req_amo_op),
    .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_word(mem_req_word), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_control(alu_control),
    .alu_amo_op(alu_amo_op), .alu_word_operation(alu_word_operation), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr)
  );

  always #5 clk = ~clk;

  // Memory: accepts a read and answers it on the next cycle; writes land on the handshake edge.
  always @(posedge clk) begin
    mem_rsp_valid <= 1'b0;
    if (mem_req_valid && mem_req_ready) begin
      if (mem_req_we) begin
        mem[mem_req_addr] = mem_req_wdata;
        wr_count     <= wr_count + 1;
        last_wr_addr <= mem_req_addr;
        last_wr_data <= mem_req_wdata;
      end else if (!mem_mute) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_rdata <= mem[mem_req_addr];
      end
    end
  end

  // Stub ALU covering ADD, SWAP and MIN.
  logic signed [63:0] sa, sb, r_full;
  always_comb begin
    sa = alu_word_operation ? {{32{alu_operand_a[31]}}, alu_operand_a[31:0]} : alu_operand_a;
    sb = alu_word_operation ? {{32{alu_operand_b[31]}}, alu_operand_b[31:0]} : alu_operand_b;
    case (alu_amo_op)
      5'b00000: r_full = sa + sb;
      5'b00001: r_full = sb;
      5'b10000: r_full = (sa < sb) ? sa : sb;
      default:  r_full = '0;
    endcase
    alu_result = alu_word_operation ? {{32{r_full[31]}}, r_full[31:0]} : r_full;
  end

  task automatic do_txn(input logic [1:0] kind, input logic [4:0] op, input logic word,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic snp, input logic [63:0] saddr,
                        output int lat, output logic [63:0] data, output int exec_cyc);
    @(negedge clk);
    req_kind = kind; req_amo_op = op; req_word = word; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1; snoop_valid = snp; snoop_addr = saddr;
    @(negedge clk);
    req_valid = 1'b0; snoop_valid = 1'b0;
    lat = -1; data = '0; exec_cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      if (alu_control == 4'b1110 && exec_cyc < 0) exec_cyc = k;
      if (rsp_valid) begin lat = k; data = rsp_data; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== 64'd0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    checks++; if (alu_control !== 4'b0000) begin errors++; $display("FAIL reset_alu_control: got %b expected 0000", alu_control); end
  endtask

  task automatic test_amo_add;
    int lat, ec, wr0; logic [63:0] d;
    mem[64'h100] = 64'd5; wr0 = wr_count;
    do_txn(2'b00, 5'b00000, 1'b0, 64'h100, 64'd3, 1'b0, 64'h0, lat, d, ec);
    checks++; if (lat !== 5) begin errors++; $display("FAIL amoadd_latency: got %0d expected 5", lat); end
    checks++; if (d !== 64'd5) begin errors++; $display("FAIL amoadd_rsp_data: got %h expected 5", d); end
    checks++; if (ec !== 3) begin errors++; $display("FAIL amoadd_exec_cycle: got %0d expected 3", ec); end
    checks++; if (mem[64'h100] !== 64'd8) begin errors++; $display("FAIL amoadd_mem: got %h expected 8", mem[64'h100]); end
    checks++; if (wr_count !== wr0 + 1 || last_wr_addr !== 64'h100) begin errors++; $display("FAIL amoadd_write: count %0d addr %h expected %0d / 100", wr_count, last_wr_addr, wr0 + 1); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL amoadd_pulse: rsp_valid %b req_ready %b expected 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_amo_min_w;
    int lat, ec; logic [63:0] d;
    mem[64'h108] = 64'h0000_0000_FFFF_FFFE;
    do_txn(2'b00, 5'b10000, 1'b1, 64'h108, 64'd1, 1'b0, 64'h0, lat, d, ec);
    checks++; if (lat !== 5) begin errors++; $display("FAIL amominw_latency: got %0d expected 5", lat); end
    checks++; if (d !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL amominw_rsp_data: got %h expected fffffffffffffffe", d); end
    checks++; if (last_wr_data !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL amominw_wdata: got %h expected fffffffffffffffe", last_wr_data); end
  endtask

  task automatic test_lr_sc;
    int lat, ec, wr0; logic [63:0] d;
    mem[64'h200] = 64'h1234_5678_9ABC_DEF0;
    do_txn(2'b01, 5'b0, 1'b0, 64'h200, 64'h0, 1'b0, 64'h0, lat, d, ec);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lr_latency: got %0d expected 3", lat); end
    checks++; if (d !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL lr_rsp_data: got %h expected 123456789abcdef0", d); end
    wr0 = wr_count;
    do_txn(2'b10, 5'b0, 1'b0, 64'h200, 64'd7, 1'b0, 64'h0, lat, d, ec);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sc_ok_latency: got %0d expected 2", lat); end
    checks++; if (d !== 64'd0) begin errors++; $display("FAIL sc_ok_rsp_data: got %h expected 0", d); end
    checks++; if (mem[64'h200] !== 64'd7 || wr_count !== wr0 + 1) begin errors++; $display("FAIL sc_ok_write: mem %h count %0d expected 7 / %0d", mem[64'h200], wr_count, wr0 + 1); end
    wr0 = wr_count;
    do_txn(2'b10, 5'b0, 1'b0, 64'h200, 64'd9, 1'b0, 64'h0, lat, d, ec);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sc_again_latency: got %0d expected 1", lat); end
    checks++; if (d !== 64'd1) begin errors++; $display("FAIL sc_again_rsp_data: got %h expected 1", d); end
    checks++; if (wr_count !== wr0) begin errors++; $display("FAIL sc_again_nowrite: count %0d expected %0d", wr_count, wr0); end
  endtask

  task automatic test_snoop;
    int lat, ec, wr0; logic [63:0] d;
    do_txn(2'b01, 5'b0, 1'b0, 64'h200, 64'h0, 1'b0, 64'h0, lat, d, ec);
    @(negedge clk); snoop_valid = 1'b1; snoop_addr = 64'h204;
    @(negedge clk); snoop_valid = 1'b0;
    wr0 = wr_count;
    do_txn(2'b10, 5'b0, 1'b0, 64'h200, 64'd7, 1'b0, 64'h0, lat, d, ec);
    checks++; if (lat !== 1 || d !== 64'd1) begin errors++; $display("FAIL snoop_sc: lat %0d data %h expected 1 / 1", lat, d); end
    checks++; if (wr_count !== wr0) begin errors++; $display("FAIL snoop_sc_nowrite: count %0d expected %0d", wr_count, wr0); end
    // Snoop to a different doubleword leaves the reservation alone.
    do_txn(2'b01, 5'b0, 1'b0, 64'h200, 64'h0, 1'b0, 64'h0, lat, d, ec);
    @(negedge clk); snoop_valid = 1'b1; snoop_addr = 64'h208;
    @(negedge clk); snoop_valid = 1'b0;
    do_txn(2'b10, 5'b0, 1'b0, 64'h200, 64'd11, 1'b0, 64'h0, lat, d, ec);
    checks++; if (lat !== 2 || d !== 64'd0) begin errors++; $display("FAIL snoop_other_sc: lat %0d data %h expected 2 / 0", lat, d); end
    // Snoop in the SC acceptance cycle.
    do_txn(2'b01, 5'b0, 1'b0, 64'h200, 64'h0, 1'b0, 64'h0, lat, d, ec);
    do_txn(2'b10, 5'b0, 1'b0, 64'h200, 64'd12, 1'b1, 64'h200, lat, d, ec);
    checks++; if (lat !== 1 || d !== 64'd1) begin errors++; $display("FAIL snoop_at_accept_sc: lat %0d data %h expected 1 / 1", lat, d); end
  endtask

  task automatic test_amo_clears_resv;
    int lat, ec; logic [63:0] d;
    mem[64'h200] = 64'h33;
    do_txn(2'b01, 5'b0, 1'b0, 64'h200, 64'h0, 1'b0, 64'h0, lat, d, ec);
    do_txn(2'b00, 5'b00001, 1'b0, 64'h200, 64'h55, 1'b0, 64'h0, lat, d, ec);
    checks++; if (d !== 64'h33 || mem[64'h200] !== 64'h55) begin errors++; $display("FAIL amoswap: data %h mem %h expected 33 / 55", d, mem[64'h200]); end
    do_txn(2'b10, 5'b0, 1'b0, 64'h200, 64'd7, 1'b0, 64'h0, lat, d, ec);
    checks++; if (lat !== 1 || d !== 64'd1) begin errors++; $display("FAIL amo_clears_resv_sc: lat %0d data %h expected 1 / 1", lat, d); end
  endtask

  task automatic test_reset_mid_op;
    int lat, ec, wr0, seen; logic [63:0] d;
    mem[64'h200] = 64'h42;
    do_txn(2'b01, 5'b0, 1'b0, 64'h200, 64'h0, 1'b0, 64'h0, lat, d, ec);
    @(negedge clk);
    mem_req_ready = 1'b0;
    req_kind = 2'b00; req_amo_op = 5'b0; req_word = 1'b0; req_addr = 64'h300; req_wdata = 64'd1; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 64'h300) begin errors++; $display("FAIL stall_hold: valid %b we %b addr %h expected 1 0 300", mem_req_valid, mem_req_we, mem_req_addr); end
      if (k == 3) begin mem_req_ready = 1'b1; mem_mute = 1'b1; end
      @(negedge clk);
    end
    checks++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rd_wait_state: mem_req_valid %b req_ready %b expected 0/0", mem_req_valid, req_ready); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: req_ready %b rsp_valid %b mem_req_valid %b expected 1 0 0", req_ready, rsp_valid, mem_req_valid); end
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_rsp: rsp_valid cycles %0d expected 0", seen); end
    mem_mute = 1'b0;
    wr0 = wr_count;
    do_txn(2'b10, 5'b0, 1'b0, 64'h200, 64'd7, 1'b0, 64'h0, lat, d, ec);
    checks++; if (lat !== 1 || d !== 64'd1 || wr_count !== wr0) begin errors++; $display("FAIL abort_resv_cleared: lat %0d data %h writes %0d expected 1 / 1 / %0d", lat, d, wr_count, wr0); end
  endtask

  task automatic test_timeout;
    int lat, ec, exp_lat; logic [63:0] d, exp_d;
`ifdef AMO_RESV_TIMEOUT_EN
    exp_lat = 1; exp_d = 64'd1;
`else
    exp_lat = 2; exp_d = 64'd0;
`endif
    do_txn(2'b01, 5'b0, 1'b0, 64'h200, 64'h0, 1'b0, 64'h0, lat, d, ec);
    repeat (10) @(negedge clk);
    do_txn(2'b10, 5'b0, 1'b0, 64'h200, 64'd21, 1'b0, 64'h0, lat, d, ec);
    checks++; if (lat !== exp_lat || d !== exp_d) begin errors++; $display("FAIL timeout_sc: lat %0d data %h expected %0d / %h", lat, d, exp_lat, exp_d); end
  endtask

  initial begin
    test_reset();
    test_amo_add();
    test_amo_min_w();
    test_lr_sc();
    test_snoop();
    test_amo_clears_resv();
    test_reset_mid_op();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
